// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants, frame defaults.
// Pure declarations; no timing or flow control of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int OS_RATE     = 16;
    localparam int MID_TICK    = 7;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

    // Tick counter must cover both a full bit (OS_RATE) and the longest stop period.
    function automatic int tick_cnt_width(input int sb_tick);
        return $clog2((sb_tick > OS_RATE) ? sb_tick : OS_RATE);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// 2-flop synchroniser for the rx line (resets to idle-high) plus a falling-edge flag.
// Latency: rxs_o lags rx_i by 2 clk; no backpressure.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rxs_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rxs_o  = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver; rx_valid rises 1 clk after the stop-bit sample tick.
// Single-entry valid/ready output register: an unconsumed word is overwritten and flagged overrun.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int SB_TICK    = SB_TICK_DEF,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun
);

    localparam int S_W = tick_cnt_width(SB_TICK);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(MID_TICK);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OS_RATE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
    localparam logic           PAR_ODD = (PARITY_ODD != 0);

    logic rxs;
    logic rx_fall;

    rx_state_e       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_err_q, p_err_d;
    logic            frame_done;
    logic            f_err;

    logic [DBIT-1:0] rx_data_q;
    logic            rx_valid_q;
    logic            frame_err_q;
    logic            parity_err_q;
    logic            overrun_q;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rx_i   (rx),
        .rxs_o  (rxs),
        .fall_o (rx_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_err_q <= p_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        b_d        = b_q;
        p_err_d    = p_err_q;
        frame_done = 1'b0;
        f_err      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Edge-triggered so a line held low (break) cannot restart a frame.
                if (rx_fall) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rxs) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rxs, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        p_err_d = (^b_q ^ rxs) != PAR_ODD;
                        state_d = STOP;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        f_err      = ~rxs;
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A new word always wins; overrun records that the held word was lost unread.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (frame_done) begin
            rx_data_q    <= b_q;
            rx_valid_q   <= 1'b1;
            frame_err_q  <= f_err;
            parity_err_q <= (PARITY_EN != 0) ? p_err_q : 1'b0;
            overrun_q    <= rx_valid_q && !rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_q   <= 1'b0;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule
